bcd_serial_adder: RTL
=====================

// Module: bcd_serial_adder
// PURPOSE
//   Digit-serial multi-digit BCD adder. Sits downstream of the 4-bit binary adder stage.
//   Each cycle, one digit pair goes through a 4-bit binary add plus carry-in.
//   The binary sum then gets decimal correction (+6 when >9), and the decimal carry is
//   registered into the next digit. Adds DIGITS-digit packed BCD operands under a
//   start/busy/done handshake.
// PARAMETERS
//   DIGITS   4   number of BCD digits per operand (>=1); one digit processed per cycle
// PORTS
//   clk     in   1          rising-edge clock
//   rst_n   in   1          asynchronous active-low reset
//   start   in   1          request; sampled only in IDLE
//   a       in   4*DIGITS   operand A, packed BCD, digit 0 = a[3:0]
//   b       in   4*DIGITS   operand B, packed BCD, digit 0 = b[3:0]
//   c_in    in   1          decimal carry into digit 0
//   busy    out  1          1 whenever state != IDLE
//   done    out  1          one-cycle pulse, result valid
//   sum     out  4*DIGITS   packed BCD result
//   c_out   out  1          decimal carry out of digit DIGITS-1
//   err     out  1          sticky: some operand digit > 9 in this operation
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//     - state=IDLE; busy=0, done=0, sum=0, c_out=0, err=0.
//     - Digit index and carry register cleared.
//     - Reset mid-operation aborts it; no done is issued.
//   - State machine: IDLE -> ADD -> DONE -> IDLE.
//   - IDLE:
//     - On start=1 at an edge: latch a, b, c_in into internal registers.
//     - Set carry=c_in, idx=0, err=0, sum=0, c_out=0. Go to ADD.
//   - ADD: one digit per edge.
//     - t = A[idx] + B[idx] + carry (5-bit).
//     - If t>9: sum[idx] = (t+6)[3:0], carry=1. Otherwise: sum[idx] = t[3:0], carry=0.
//     - err |= (A[idx]>9) | (B[idx]>9).
//     - On idx==DIGITS-1: c_out = new carry, go to DONE. Otherwise idx++.
//   - DONE: done=1 for exactly this one cycle; next edge goes to IDLE.
//   - Latency: start sampled at edge k; done is high in the cycle after edge k+DIGITS.
//     Next start is accepted at edge k+DIGITS+2 at the earliest.
//   - start is ignored in ADD and DONE. No queuing, and latched operands are not
//     disturbed. a/b/c_in may change freely after the accepting edge.
//   - sum, c_out and err are registered outputs.
//     - They hold their final values after done until the next accepted start,
//       which clears them.
//     - sum digits fill progressively during ADD; sum is valid only when done=1.
//   - Invalid digits (>9) are still processed by the same rule, and err flags them.
//     Max t=31 gives digit (37)[3:0]=5, carry 1.
//   - DIGITS=1: ADD lasts one cycle.
// TESTING (DIGITS=4)
//   1. a=16'h1234, b=16'h5678, c_in=0, start pulse
//      -> done at edge k+4; sum=16'h6912, c_out=0, err=0, busy=1 for 5 cycles.
//   2. a=16'h9999, b=16'h0001, c_in=0
//      -> sum=16'h0000, c_out=1, err=0 (carry ripples through all digits).
//   3. a=16'h9999, b=16'h9999, c_in=1
//      -> sum=16'h9999, c_out=1, err=0.
//   4. a=16'h00A0, b=16'h0000, c_in=0
//      -> sum=16'h0100, c_out=0, err=1; next valid op clears err to 0.
//   5. start held high continuously
//      -> ops back-to-back every 6 cycles; start high in ADD/DONE is ignored.
//      -> Changing a/b during ADD does not alter the result.
//   6. rst_n=0 during ADD (idx=2)
//      -> busy/done/sum/c_out/err go 0 immediately, with no done pulse.
//      -> After release, case 1 again gives 16'h6912.

Source files
------------

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit pair per cycle, decimal-corrected, carry rippled by register.
// Latency: start at edge k, done pulses in the cycle after edge k+DIGITS; next start at k+DIGITS+2.
// Backpressure: none queued; start is only honoured in IDLE and ignored while busy.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             operation request (sampled in IDLE only)
//   a, b, c_in        packed BCD operands (digit 0 in [3:0]) and carry into digit 0
//   busy              high whenever the FSM is not IDLE
//   done              one-cycle pulse, sum/c_out/err valid
//   sum, c_out, err   registered result, decimal carry out, sticky invalid-digit flag
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  c_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  c_out,
  output logic                  err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [4*DIGITS-1:0] r_a;
  logic [4*DIGITS-1:0] r_b;
  logic [IW-1:0]       r_idx;
  logic                r_carry;
  logic [4*DIGITS-1:0] r_sum;
  logic                r_c_out;
  logic                r_err;
  logic                r_busy;
  logic                r_done;

  logic [IW+1:0] w_base;
  logic [3:0]    w_da;
  logic [3:0]    w_db;
  logic [4:0]    w_t;
  logic [4:0]    w_adj;
  logic          w_gt9;
  logic [3:0]    w_digit;
  logic          w_bad;
  logic          w_last;

  // Bit offset of the current digit: idx*4.
  assign w_base  = {r_idx, 2'b00};
  assign w_da    = r_a[w_base +: 4];
  assign w_db    = r_b[w_base +: 4];
  assign w_t     = {1'b0, w_da} + {1'b0, w_db} + {4'b0000, r_carry};
  assign w_adj   = w_t + 5'd6;
  assign w_gt9   = (w_t > 5'd9);
  // Correction wraps mod 16, so even invalid-digit sums up to 31 yield a 4-bit digit.
  assign w_digit = w_gt9 ? w_adj[3:0] : w_t[3:0];
  assign w_bad   = (w_da > 4'd9) | (w_db > 4'd9);
  assign w_last  = (r_idx == IW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum[w_base +: 4] <= w_digit;
          r_carry            <= w_gt9;
          r_err              <= r_err | w_bad;
          if (w_last) begin
            r_c_out <= w_gt9;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_c_out;
  assign err   = r_err;

endmodule
